// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative decryptor and the key-step block:
// FSM state encoding, round constants, GF(2^8) arithmetic and the inverse
// round transforms. Byte 0 of a 128-bit block sits in [127:120]; bytes are
// column-major (byte n is row n%4, column n/4).
package aes_pkg;

  localparam int NR = 10;                 // AES-128 round count
  localparam int KW = 128;                // key/data width
  localparam int CW = $clog2(NR + 1);     // round counter width

  typedef enum logic [2:0] {IDLE, KEXP, ADD, ROUND, FINAL, DONE} state_e;

  localparam logic [7:0] RCON [1:NR] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // Multiply by x modulo x^8+x^4+x^3+x+1 (0x11B).
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gmul(a, a);
    x3   = gmul(x2, a);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = x15;
    for (int i = 0; i < 4; i++) x240 = gmul(x240, x240);
    return gmul(gmul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  // Row r rotates right by r columns.
  function automatic logic [KW-1:0] inv_shift_rows(input logic [KW-1:0] s);
    logic [KW-1:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[KW-1-8*(r+4*c) -: 8] = s[KW-1-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [KW-1:0] inv_sub_bytes(input logic [KW-1:0] s);
    logic [KW-1:0] o;
    for (int n = 0; n < 16; n++) o[KW-1-8*n -: 8] = inv_sbox(s[KW-1-8*n -: 8]);
    return o;
  endfunction

  function automatic logic [KW-1:0] inv_mix_columns(input logic [KW-1:0] s);
    logic [KW-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[KW-1-32*c -: 8];
      a1 = s[KW-9-32*c -: 8];
      a2 = s[KW-17-32*c -: 8];
      a3 = s[KW-25-32*c -: 8];
      o[KW-1-32*c -: 8]  = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[KW-9-32*c -: 8]  = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[KW-17-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[KW-25-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One forward AES-128 key-expansion step: previous round key plus Rcon in,
// next round key out. Purely combinational so an encryptor can share it.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [KW-1:0] key_i,
  input  logic [7:0]    rcon_i,
  output logic [KW-1:0] key_o
);

  logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_i;

  // SubWord(RotWord(w3)) ^ Rcon, then the XOR chain across the four words.
  assign t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
              ^ {rcon_i, 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: expands the key forward into an 11-entry
// round-key store, then runs the inverse cipher one round per clock.
// Optional build macro KEY_CACHE_EN skips key expansion when the presented
// key equals the one already expanded.
module aes_decrypt_iter
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [KW-1:0] data_in,
  input  logic [KW-1:0] key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [KW-1:0] data_out,
  output logic          busy
);

  localparam logic [CW-1:0] CNT_LAST = CW'(NR);

  state_e        st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] blk_q, blk_d;
  logic [KW-1:0] dout_q, dout_d;
  logic          out_valid_q, out_valid_d;
  logic [KW-1:0] rk_q [0:NR];
  logic          rk_we;
  logic [CW-1:0] rk_idx;
  logic [KW-1:0] rk_wdata, rk_next;
  logic [7:0]    rcon_sel;
  logic          cache_hit;

  // Round constant for the key step; zero outside the expansion range.
  always_comb begin
    rcon_sel = 8'h00;
    if (cnt_q != '0 && cnt_q <= CNT_LAST) rcon_sel = RCON[cnt_q];
  end

  aes_key_step u_key_step (
    .key_i  (rk_q[cnt_q - 1'b1]),
    .rcon_i (rcon_sel),
    .key_o  (rk_next)
  );

`ifdef KEY_CACHE_EN
  logic key_cached_q;

  // Mark the store valid once a full expansion has completed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 key_cached_q <= 1'b0;
    else if (st_q == KEXP && cnt_q == CNT_LAST) key_cached_q <= 1'b1;
  end

  assign cache_hit = key_cached_q && (key == rk_q[0]);
`else
  assign cache_hit = 1'b0;
`endif

  // Next-state, datapath and round-key write control.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    st_d        = st_q;
    cnt_d       = cnt_q;
    blk_d       = blk_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    rk_we       = 1'b0;
    rk_idx      = cnt_q;
    rk_wdata    = rk_next;
    case (st_q)
      IDLE: if (in_valid) begin
        blk_d    = data_in;
        rk_we    = 1'b1;
        rk_idx   = '0;
        rk_wdata = key;
        if (cache_hit) begin
          st_d = ADD;
        end else begin
          st_d  = KEXP;
          cnt_d = CW'(1);
        end
      end
      KEXP: begin
        rk_we = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) st_d = ADD;
      end
      ADD: begin
        blk_d = blk_q ^ rk_q[NR];
        cnt_d = CNT_LAST - 1'b1;
        st_d  = ROUND;
      end
      ROUND: begin
        blk_d = inv_mix_columns(inv_sub_bytes(inv_shift_rows(blk_q)) ^ rk_q[cnt_q]);
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) st_d = FINAL;
      end
      FINAL: begin
        dout_d      = inv_sub_bytes(inv_shift_rows(blk_q)) ^ rk_q[0];
        out_valid_d = 1'b1;
        st_d        = DONE;
      end
      DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        st_d        = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (!rst_n) st_q <= IDLE;
    else        st_q <= st_d;
  end

  // Datapath registers: round counter, cipher state, result and valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      blk_q       <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      blk_q       <= blk_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Round-key store, one write port.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the store is cleared on reset so no stale key material survives an
    // abort; this keeps it in flops rather than a RAM macro.
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else if (rk_we) begin
      rk_q[rk_idx] <= rk_wdata;
    end
  end

  assign in_ready  = (st_q == IDLE);
  assign busy      = (st_q != IDLE);
  assign out_valid = out_valid_q;
  assign data_out  = dout_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Scoreboard bench for aes_decrypt_iter using FIPS-197 vectors. Latency is
// counted in rising edges from the accept edge (counted as 1) through the
// edge that raises out_valid.
module tb_aes_decrypt_iter;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
`ifdef KEY_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         busy;

  aes_decrypt_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] pt;
    int           lat;
    int           acc;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         cur;
  bit           have_cur = 1'b0;
  bit           seen = 1'b0;
  int           n_out = 0;
  int           hs_edge = 0;
  int           checks = 0;
  int           errors = 0;
  bit           m_cached = 1'b0;
  logic [127:0] m_key = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input logic [127:0] k);
    if (CACHE_ON && m_cached && k == m_key) return 12;
    return 22;
  endfunction

  // Present one request and hold it until accepted; push the expectation.
  task automatic send(input logic [127:0] k, input logic [127:0] ct,
                      input logic [127:0] pt, output int acc);
    int lat;
    in_valid = 1'b1;
    key      = k;
    data_in  = ct;
    acc      = -1;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        acc = cyc + 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready low, expected high");
    end else begin
      lat = exp_latency(k);
      sb_q.push_back('{pt, lat, acc});
      if (lat == 22) begin
        m_cached = 1'b1;
        m_key    = k;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 200 && n_out < target; i++) begin
      @(posedge clk); #1;
    end
    if (n_out < target) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: outputs %0d, expected %0d", n_out, target);
    end
  endtask

  // Monitor: compare each presented result against the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      seen     = 1'b0;
      have_cur = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin
        seen = 1'b1;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          have_cur = 1'b0;
          $display("FAIL unexpected_output: got %h, expected none", data_out);
        end else begin
          cur      = sb_q.pop_front();
          have_cur = 1'b1;
          check("plaintext", data_out, cur.pt);
          check("latency", 128'(cyc - cur.acc + 1), 128'(cur.lat));
        end
      end else if (have_cur) begin
        check("hold", data_out, cur.pt);
      end
      if (out_ready) begin
        seen    = 1'b0;
        hs_edge = cyc + 1;
        n_out++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, acc2, n_exp;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    key       = '0;
    out_ready = 1'b0;
    n_exp     = 0;
    #12;
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_data_out", data_out, '0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // App. B then App. C.1.
    send(KEY_B, CT_B, PT_B, acc); n_exp++; wait_done(n_exp);
    send(KEY_C, CT_C, PT_C, acc); n_exp++; wait_done(n_exp);

    // Backpressure with ignored in_valid pulses while holding the result.
    out_ready = 1'b0;
    send(KEY_B, CT_B, PT_B, acc); n_exp++;
    for (int i = 0; i < 100 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    check("bp_out_valid", 128'(out_valid), 128'(1));
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 128'(in_ready), 128'(0));
      check("bp_data_out", data_out, PT_B);
      in_valid = (i % 2 == 0);
      key      = KEY_C;
      data_in  = CT_C;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 128'(in_ready), 128'(1));
    check("bp_release_out_valid", 128'(out_valid), 128'(0));
    wait_done(n_exp);

    // Asynchronous reset during the eighth key-expansion cycle.
    send(KEY_B, CT_B, PT_B, acc);
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_in_ready", 128'(in_ready), 128'(1));
    check("abort_out_valid", 128'(out_valid), 128'(0));
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_data_out", data_out, '0);
    sb_q.delete();
    m_cached = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(KEY_B, CT_B, PT_B, acc); n_exp++; wait_done(n_exp);

    // Back-to-back: second request waits with in_valid held high.
    send(KEY_B, CT_B, PT_B, acc);  n_exp++;
    send(KEY_C, CT_C, PT_C, acc2); n_exp++;
    check("b2b_gap", 128'(acc2 - hs_edge), 128'(1));
    wait_done(n_exp);

    // Repeated key, then a different key.
    send(KEY_B, CT_B, PT_B, acc); n_exp++; wait_done(n_exp);
    send(KEY_B, CT_B, PT_B, acc); n_exp++; wait_done(n_exp);
    send(KEY_C, CT_C, PT_C, acc); n_exp++; wait_done(n_exp);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 128'(sb_q.size()), 128'(0));
    check("outputs_seen", 128'(n_out), 128'(n_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
